// File: rtl/command_queue_pkg.sv
// Shared types and defaults for the display command queue between i2c_slave and tpu.
package command_queue_pkg;

  localparam int CQ_DEPTH      = 16;
  localparam int CQ_WIDTH      = 48;
  localparam int CQ_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    CQ_IDLE  = 2'd0,
    CQ_ISSUE = 2'd1,
    CQ_GAP   = 2'd2,
    CQ_WAIT  = 2'd3
  } cq_state_e;

  function automatic logic [15:0] cq_sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/command_queue_ram.sv
// DEPTH x WIDTH command storage: synchronous write, asynchronous read at the head pointer.
module command_queue_ram
  import command_queue_pkg::*;
#(
  parameter int DEPTH = CQ_DEPTH,
  parameter int WIDTH = CQ_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/command_queue.sv
// FIFO of display commands from i2c_slave to tpu, issuing one command per tpu-idle window.
// Optional statistics outputs (drop_count, high_water) under macro COMMAND_QUEUE_STATS_EN.
module command_queue
  import command_queue_pkg::*;
#(
  parameter int DEPTH      = CQ_DEPTH,
  parameter int WIDTH      = CQ_WIDTH,
  parameter int GAP_CYCLES = CQ_GAP_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_execute,
  input  logic [WIDTH-1:0]         in_command,
  output logic                     in_busy,
  input  logic                     flush,
  output logic                     out_execute,
  output logic [WIDTH-1:0]         out_command,
  input  logic                     out_busy,
  output logic [$clog2(DEPTH):0]   level
`ifdef COMMAND_QUEUE_STATS_EN
  ,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  cq_state_e        state_r, state_s;
  logic [AW-1:0]    head_r, tail_r;
  logic [LW-1:0]    level_r, level_s;
  logic [GW-1:0]    gap_cnt_r;
  logic             in_busy_r;
  logic             out_execute_r;
  logic [WIDTH-1:0] out_command_r;
  logic [WIDTH-1:0] head_data_s;
  logic             push_s, pop_s;

  // in_busy is registered, so a push seen while full is rejected even if a pop happens that cycle
  assign push_s = in_execute && !in_busy_r && !flush;

  command_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (tail_r),
    .wdata (in_command),
    .raddr (head_r),
    .rdata (head_data_s)
  );

  // next-state logic; the pop happens on the edge entering ISSUE
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      CQ_IDLE: begin
        if ((level_r != {LW{1'b0}}) && !out_busy && !flush) begin
          state_s = CQ_ISSUE;
          pop_s   = 1'b1;
        end else begin
          state_s = CQ_IDLE;
        end
      end
      CQ_ISSUE: state_s = CQ_GAP;
      CQ_GAP: begin
        if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
          state_s = CQ_WAIT;
        end else begin
          state_s = CQ_GAP;
        end
      end
      CQ_WAIT: begin
        if (!out_busy) begin
          state_s = CQ_IDLE;
        end else begin
          state_s = CQ_WAIT;
        end
      end
      default: state_s = CQ_IDLE;
    endcase
  end

  // next fill level
  always_comb begin
    level_s = level_r;
    if (flush) begin
      level_s = {LW{1'b0}};
    end else if (push_s && !pop_s) begin
      level_s = level_r + LW'(1);
    end else if (!push_s && pop_s) begin
      level_s = level_r - LW'(1);
    end else begin
      level_s = level_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= CQ_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // GAP dwell counter, restarted whenever the FSM is elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_r <= {GW{1'b0}};
    end else if (state_r != CQ_GAP) begin
      gap_cnt_r <= {GW{1'b0}};
    end else begin
      gap_cnt_r <= gap_cnt_r + GW'(1);
    end
  end

  // pointers, level and full flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r    <= {AW{1'b0}};
      tail_r    <= {AW{1'b0}};
      level_r   <= {LW{1'b0}};
      in_busy_r <= 1'b0;
    end else begin
      level_r   <= level_s;
      in_busy_r <= (level_s == LW'(DEPTH));
      if (flush) begin
        head_r <= {AW{1'b0}};
        tail_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          tail_r <= tail_r + AW'(1);
        end
        if (pop_s) begin
          head_r <= head_r + AW'(1);
        end
      end
    end
  end

  // issue strobe and held command to tpu
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_execute_r <= 1'b0;
      out_command_r <= {WIDTH{1'b0}};
    end else begin
      out_execute_r <= pop_s;
      if (pop_s) begin
        out_command_r <= head_data_s;
      end
    end
  end

  assign in_busy     = in_busy_r;
  assign out_execute = out_execute_r;
  assign out_command = out_command_r;
  assign level       = level_r;

`ifdef COMMAND_QUEUE_STATS_EN
  logic [15:0]   drop_count_r;
  logic [LW-1:0] high_water_r;

  // statistics survive flush; only reset clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count_r <= 16'd0;
      high_water_r <= {LW{1'b0}};
    end else begin
      if (in_execute && in_busy_r) begin
        drop_count_r <= cq_sat_inc16(drop_count_r);
      end
      if (level_s > high_water_r) begin
        high_water_r <= level_s;
      end
    end
  end

  assign drop_count = drop_count_r;
  assign high_water = high_water_r;
`endif

endmodule

// File: tb/tb_command_queue.sv
// Directed bench for command_queue: vector table plus hand-written full/wrap/flush/reset sequences.
module tb_command_queue;

  localparam logic [47:0] CMD_A = 48'h0102_0304_0506;
  localparam logic [47:0] CMD_B = 48'h1111_2222_3333;
  localparam logic [47:0] CMD_C = 48'hAAAA_BBBB_CCCC;
  localparam logic [47:0] CMD_D = 48'h0F0F_F0F0_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_execute;
  logic [47:0] in_command;
  logic        in_busy;
  logic        flush;
  logic        out_execute;
  logic [47:0] out_command;
  logic        out_busy;
  logic [4:0]  level;
`ifdef COMMAND_QUEUE_STATS_EN
  logic [15:0] drop_count;
  logic [4:0]  high_water;
`endif

  int n_vec = 0;
  int n_bad = 0;

  command_queue dut (
    .clk         (clk),
    .reset       (reset),
    .in_execute  (in_execute),
    .in_command  (in_command),
    .in_busy     (in_busy),
    .flush       (flush),
    .out_execute (out_execute),
    .out_command (out_command),
    .out_busy    (out_busy),
    .level       (level)
`ifdef COMMAND_QUEUE_STATS_EN
    ,
    .drop_count  (drop_count),
    .high_water  (high_water)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exec;
    logic [47:0] cmd;
    logic        busy;
    logic        fl;
    logic        e_exec;
    logic [47:0] e_cmd;
    logic [4:0]  e_level;
    logic        e_in_busy;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic exec, input logic [47:0] cmd, input logic busy,
                              input logic fl, input logic e_exec, input logic [47:0] e_cmd,
                              input logic [4:0] e_level, input logic e_in_busy);
    vec_t v;
    v.exec = exec; v.cmd = cmd; v.busy = busy; v.fl = fl;
    v.e_exec = e_exec; v.e_cmd = e_cmd; v.e_level = e_level; v.e_in_busy = e_in_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then sample just after the edge
  task automatic apply(input logic exec, input logic [47:0] cmd, input logic busy, input logic fl);
    in_execute = exec;
    in_command = cmd;
    out_busy   = busy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  // run n cycles with tpu idle, returning the number of issues seen
  task automatic drain(input int n, input logic [47:0] base, input int expected, input string tag);
    int cnt;
    int last;
    cnt  = 0;
    last = 0;
    for (int c = 0; c < n; c++) begin
      apply(1'b0, 48'h0, 1'b0, 1'b0);
      if (out_execute) begin
        chk({tag, "_order"}, out_command, base + 48'(cnt));
        if (cnt > 0) chk({tag, "_spacing"}, 64'((c - last) >= 4), 64'd1);
        last = c;
        cnt++;
      end
    end
    chk({tag, "_count"}, 64'(cnt), 64'(expected));
    chk({tag, "_level"}, 64'(level), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_execute = 1'b0; in_command = 48'h0; out_busy = 1'b0; flush = 1'b0;

    tbl[0]  = mk(1'b1, CMD_A, 1'b0, 1'b0, 1'b0, 48'h0,  5'd1, 1'b0);
    tbl[1]  = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, CMD_A, 5'd0, 1'b0);
    tbl[2]  = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_A, 5'd0, 1'b0);
    tbl[3]  = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_A, 5'd0, 1'b0);
    tbl[4]  = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_A, 5'd0, 1'b0);
    tbl[5]  = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_A, 5'd0, 1'b0);
    tbl[6]  = mk(1'b1, CMD_B, 1'b1, 1'b0, 1'b0, CMD_A, 5'd1, 1'b0);
    tbl[7]  = mk(1'b1, CMD_C, 1'b1, 1'b0, 1'b0, CMD_A, 5'd2, 1'b0);
    tbl[8]  = mk(1'b1, CMD_D, 1'b1, 1'b0, 1'b0, CMD_A, 5'd3, 1'b0);
    tbl[9]  = mk(1'b0, 48'h0, 1'b1, 1'b0, 1'b0, CMD_A, 5'd3, 1'b0);
    tbl[10] = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, CMD_B, 5'd2, 1'b0);
    for (int i = 11; i < 15; i++) tbl[i] = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_B, 5'd2, 1'b0);
    tbl[15] = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, CMD_C, 5'd1, 1'b0);
    for (int i = 16; i < 20; i++) tbl[i] = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_C, 5'd1, 1'b0);
    tbl[20] = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b1, CMD_D, 5'd0, 1'b0);
    tbl[21] = mk(1'b0, 48'h0, 1'b0, 1'b0, 1'b0, CMD_D, 5'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_execute, out_command, level, in_busy}, 64'h0);
    reset = 1'b0;

    // single push latency and FIFO release after tpu busy
    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].exec, tbl[i].cmd, tbl[i].busy, tbl[i].fl);
      chk($sformatf("vec%0d", i), {out_execute, out_command, level, in_busy},
          {tbl[i].e_exec, tbl[i].e_cmd, tbl[i].e_level, tbl[i].e_in_busy});
    end
    repeat (4) apply(1'b0, 48'h0, 1'b0, 1'b0);

    // overfill with tpu busy: 16 kept, 2 dropped
    for (int i = 0; i < 18; i++) begin
      apply(1'b1, 48'hC0DE_0000_0000 + 48'(i), 1'b1, 1'b0);
      if (i == 14) chk("in_busy_at_15", 64'(in_busy), 64'd0);
      if (i == 15) chk("in_busy_at_16", 64'(in_busy), 64'd1);
    end
    chk("full_level", 64'(level), 64'd16);
`ifdef COMMAND_QUEUE_STATS_EN
    chk("drop_count", 64'(drop_count), 64'd2);
    chk("high_water", 64'(high_water), 64'd16);
`endif
    drain(120, 48'hC0DE_0000_0000, 16, "full_drain");

    // simultaneous push and pop at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) apply(1'b1, 48'hE000_0000_0000 + 48'(i), 1'b1, 1'b0);
    chk("pre_wrap_level", 64'(level), 64'd5);
    for (int k = 0; k < 12; k++) begin
      apply(1'b1, 48'hE000_0000_0000 + 48'(k + 5), 1'b0, 1'b0);
      chk($sformatf("pushpop%0d", k), {out_execute, out_command, level},
          {1'b1, 48'hE000_0000_0000 + 48'(k), 5'd5});
      for (int j = 0; j < 4; j++) apply(1'b0, 48'h0, 1'b0, 1'b0);
      chk($sformatf("pushpop_hold%0d", k), {out_execute, level}, {1'b0, 5'd5});
    end
    drain(40, 48'hE000_0000_000C, 5, "wrap_drain");

    // flush during WAIT with 4 entries left
    for (int i = 0; i < 5; i++) apply(1'b1, 48'hF000_0000_0000 + 48'(i), 1'b1, 1'b0);
    apply(1'b0, 48'h0, 1'b0, 1'b0);
    chk("flush_issue", {out_execute, out_command, level}, {1'b1, 48'hF000_0000_0000, 5'd4});
    repeat (5) apply(1'b0, 48'h0, 1'b1, 1'b0);
    apply(1'b1, 48'hDEAD_DEAD_DEAD, 1'b1, 1'b1);
    chk("flush_level", {level, in_busy}, {5'd0, 1'b0});
    apply(1'b0, 48'h0, 1'b1, 1'b0);
    chk("flush_push_discarded", 64'(level), 64'd0);
    drain(20, 48'h0, 0, "post_flush");
    chk("flush_cmd_held", out_command, 48'hF000_0000_0000);

    // reset asserted during GAP with 7 queued
    for (int i = 0; i < 8; i++) apply(1'b1, 48'h6000_0000_0000 + 48'(i), 1'b1, 1'b0);
    apply(1'b0, 48'h0, 1'b0, 1'b0);
    chk("pre_reset_issue", {out_execute, level}, {1'b1, 5'd7});
    apply(1'b0, 48'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {out_execute, out_command, level, in_busy}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drain(20, 48'h0, 0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
